// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field layout, widths.
// Pure declarations; no latency.
// No flow control of its own.
package decode_pkg;

  localparam int REG_AW = 4;
  localparam int DATA_W = 16;
  localparam int OP_W   = 6;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [OP_W-1:0] NOP_OP = 6'b000000;
  localparam logic [OP_W-1:0] LD_OP  = 6'b010111;
  localparam logic [OP_W-1:0] ST_OP  = 6'b010001;

  // Instruction field bit positions (imm16 overlaps the low bits of rt).
  localparam int USE_IMM_BIT = 31;
  localparam int OP_HI  = 30;
  localparam int OP_LO  = 25;
  localparam int RD_HI  = 24;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 13;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic              use_imm;
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [DATA_W-1:0] imm16;
  } instr_f_t;

  // Break a raw 32-bit instruction word into its named fields.
  function automatic instr_f_t split_instr(input logic [31:0] word);
    instr_f_t f;
    f.use_imm = word[USE_IMM_BIT];
    f.opcode  = word[OP_HI:OP_LO];
    f.rd      = word[RD_HI:RD_LO];
    f.rs      = word[RS_HI:RS_LO];
    f.rt      = word[RT_HI:RT_LO];
    f.imm16   = word[IMM_HI:IMM_LO];
    return f;
  endfunction

  // Operand source select for one read port. The EX result wins over the
  // write-back value, which wins over the stored register. The EX result is
  // only usable for non-load writers; a load's data shows up on write-back.
  function automatic logic [DATA_W-1:0] fwd_operand(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_ok,
    input logic [REG_AW-1:0] ex_rd,
    input logic [DATA_W-1:0] ex_val,
    input logic              wb_ok,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] v;
    v = rf_val;
    if (wb_ok && addr == wb_rd && addr != '0) v = wb_val;
    if (ex_ok && addr == ex_rd) v = ex_val;
    return v;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 16x16 register file: three asynchronous read ports, one synchronous write port.
// Reads are combinational (0 cycles); writes land at the next rising edge.
// No backpressure; a write is always taken. R0 reads zero and ignores writes.
module decode_regfile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] addr_s,
  input  logic [REG_AW-1:0] addr_t,
  input  logic [REG_AW-1:0] addr_d,
  output logic [DATA_W-1:0] data_s,
  output logic [DATA_W-1:0] data_t,
  output logic [DATA_W-1:0] data_d,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage: cleared by reset, otherwise takes the write-back port (never R0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports; R0 is forced to zero independent of storage contents.
  always_comb begin
    data_s = (addr_s == '0) ? '0 : regs[addr_s];
    data_t = (addr_t == '0) ? '0 : regs[addr_t];
    data_d = (addr_d == '0) ? '0 : regs[addr_d];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / operand fetch: reads registers with EX and write-back bypass, issues a registered bundle to EX.
// Latency 1 cycle from accept to outputs; a load followed by a dependent instruction costs one bubble.
// instr_ready drops when EX stalls (ex_ready=0, everything holds) or on a load-use hazard.
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              ex_ready,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [OP_W-1:0]   op_dec,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] data_in,
  output logic [REG_AW-1:0] rd_ex,
  output logic              valid_ex
);

  instr_f_t          fld;
  logic [DATA_W-1:0] rf_s;
  logic [DATA_W-1:0] rf_t;
  logic [DATA_W-1:0] rf_d;

  // Tracking of the instruction currently held in EX.
  logic ex_writes;
  logic ex_is_load;

  logic              is_store;
  logic              use_rt;
  logic              ex_fwd_ok;
  logic              load_use;
  logic              accept;
  logic              nxt_writes;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;
  logic [DATA_W-1:0] nxt_din;

  assign fld = split_instr(instr);

  decode_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .addr_s  (fld.rs),
    .addr_t  (fld.rt),
    .addr_d  (fld.rd),
    .data_s  (rf_s),
    .data_t  (rf_t),
    .data_d  (rf_d),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  // Hazard detection, handshake and operand selection for the presented instruction.
  always_comb begin
    is_store  = (fld.opcode == ST_OP);
    use_rt    = ~fld.use_imm;
    // ex_writes already implies rd_ex != 0, so R0 never forwards or stalls.
    ex_fwd_ok = valid_ex & ex_writes & ~ex_is_load;

    load_use  = valid_ex & ex_is_load & ex_writes &
                ((fld.rs == rd_ex) |
                 (use_rt   & (fld.rt == rd_ex)) |
                 (is_store & (fld.rd == rd_ex)));

    instr_ready = ex_ready & ~load_use;
    accept      = instr_valid & instr_ready;

    nxt_writes = (fld.opcode != ST_OP) & (fld.opcode != NOP_OP) & (fld.rd != '0);

    nxt_a = fwd_operand(fld.rs, rf_s, ex_fwd_ok, rd_ex, ans_ex, wb_en, wb_addr, wb_data);

    nxt_b = fld.imm16;
    if (use_rt) begin
      nxt_b = fwd_operand(fld.rt, rf_t, ex_fwd_ok, rd_ex, ans_ex, wb_en, wb_addr, wb_data);
    end

    // Store data is only meaningful for stores; other instructions carry zero.
    nxt_din = '0;
    if (is_store) begin
      nxt_din = fwd_operand(fld.rd, rf_d, ex_fwd_ok, rd_ex, ans_ex, wb_en, wb_addr, wb_data);
    end
  end

  // Issue register: load on accept, bubble when EX is free but nothing issues, hold when EX stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_dec     <= NOP_OP;
      A          <= '0;
      B          <= '0;
      data_in    <= '0;
      rd_ex      <= '0;
      valid_ex   <= 1'b0;
      ex_writes  <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (ex_ready) begin
      if (accept) begin
        op_dec     <= fld.opcode;
        A          <= nxt_a;
        B          <= nxt_b;
        data_in    <= nxt_din;
        rd_ex      <= fld.rd;
        valid_ex   <= 1'b1;
        ex_writes  <= nxt_writes;
        ex_is_load <= (fld.opcode == LD_OP);
      end else begin
        // Operand fields keep their last values; only the control marks the bubble.
        op_dec    <= NOP_OP;
        valid_ex  <= 1'b0;
        ex_writes <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, a reset-mid-stall sequence, then random traffic
// checked against a behavioural model of the decode rules.
// Inputs change 1ns after the rising edge; instr_ready is sampled at the falling edge, outputs 1ns after the rising edge.
module tb_decode_stage;

  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] LD  = 6'b010111;
  localparam logic [5:0] ST  = 6'b010001;
  localparam logic [5:0] ADD = 6'b001010;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ex_ready;
  logic [15:0] ans_ex;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [5:0]  op_dec;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [15:0] data_in;
  logic [3:0]  rd_ex;
  logic        valid_ex;

  int n_chk;
  int n_pass;

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ex_ready    (ex_ready),
    .ans_ex      (ans_ex),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .op_dec      (op_dec),
    .A           (a_out),
    .B           (b_out),
    .data_in     (data_in),
    .rd_ex       (rd_ex),
    .valid_ex    (valid_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        iv;
    logic        er;
    logic [15:0] ans;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        chk_rdy;
    logic        rdy;
    logic [5:0]  op;
    logic        v;
    logic        chk_dat;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] din;
    logic [3:0]  rd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
    logic [31:0] x;
    x = '0;
    x[30:25] = op;
    x[24:21] = rd;
    x[20:17] = rs;
    x[16:13] = rt;
    return x;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [15:0] imm);
    logic [31:0] x;
    x = '0;
    x[31]    = 1'b1;
    x[30:25] = op;
    x[24:21] = rd;
    x[20:17] = rs;
    x[15:0]  = imm;
    return x;
  endfunction

  function automatic vec_t mkv(
    input logic rst, input logic [31:0] ins, input logic iv, input logic er,
    input logic [15:0] ans, input logic we, input logic [3:0] wa, input logic [15:0] wd,
    input logic chk_rdy, input logic rdy, input logic [5:0] op, input logic v,
    input logic chk_dat, input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] din, input logic [3:0] rd);
    vec_t t;
    t.rst = rst; t.ins = ins; t.iv = iv; t.er = er; t.ans = ans;
    t.we = we; t.wa = wa; t.wd = wd; t.chk_rdy = chk_rdy; t.rdy = rdy;
    t.op = op; t.v = v; t.chk_dat = chk_dat; t.a = a; t.b = b; t.din = din; t.rd = rd;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic [31:0] ins, input logic iv, input logic er,
                       input logic [15:0] ans, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd);
    reset = rst; instr = ins; instr_valid = iv; ex_ready = er;
    ans_ex = ans; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  // One cycle of a directed vector: drive, check ready mid-cycle, clock, check the issued bundle.
  task automatic run_vec(input string tag, input vec_t t);
    drive(t.rst, t.ins, t.iv, t.er, t.ans, t.we, t.wa, t.wd);
    @(negedge clk);
    if (t.chk_rdy) check({tag, ".ready"}, {31'b0, instr_ready}, {31'b0, t.rdy});
    @(posedge clk);
    #1;
    check({tag, ".op_dec"}, {26'b0, op_dec}, {26'b0, t.op});
    check({tag, ".valid_ex"}, {31'b0, valid_ex}, {31'b0, t.v});
    if (t.chk_dat) begin
      check({tag, ".A"}, {16'b0, a_out}, {16'b0, t.a});
      check({tag, ".B"}, {16'b0, b_out}, {16'b0, t.b});
      check({tag, ".data_in"}, {16'b0, data_in}, {16'b0, t.din});
      check({tag, ".rd_ex"}, {28'b0, rd_ex}, {28'b0, t.rd});
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [15:0] m_rf [16];
  logic        m_v;
  logic        m_wr;
  logic        m_ld;
  logic [5:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [15:0] m_din;
  logic [3:0]  m_rd;

  // Value a read of register ad sees this cycle, given what is in EX and on write-back.
  function automatic logic [15:0] m_read(input logic [3:0] ad);
    if (m_v && m_wr && !m_ld && ad == m_rd) return ans_ex;
    if (wb_en && ad == wb_addr && ad != 4'd0) return wb_data;
    return m_rf[ad];
  endfunction

  function automatic logic m_ready();
    logic [5:0] op;
    logic       hit;
    op  = instr[30:25];
    hit = (instr[20:17] == m_rd) ||
          (!instr[31] && instr[16:13] == m_rd) ||
          (op == ST && instr[24:21] == m_rd);
    return ex_ready && !(m_v && m_ld && m_wr && hit);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [5:0]  op;
    logic [15:0] na, nb, nd;
    logic        acc;
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_v = 0; m_wr = 0; m_ld = 0; m_op = NOP; m_a = 0; m_b = 0; m_din = 0; m_rd = 0;
    end else begin
      op  = instr[30:25];
      acc = instr_valid && m_ready();
      na  = m_read(instr[20:17]);
      nb  = instr[31] ? instr[15:0] : m_read(instr[16:13]);
      nd  = (op == ST) ? m_read(instr[24:21]) : 16'h0;
      if (ex_ready) begin
        if (acc) begin
          m_op = op; m_a = na; m_b = nb; m_din = nd; m_rd = instr[24:21]; m_v = 1;
          m_wr = (op != ST) && (op != NOP) && (instr[24:21] != 4'd0);
          m_ld = (op == LD);
        end else begin
          m_op = NOP; m_v = 0; m_wr = 0;
        end
      end
      if (wb_en && wb_addr != 4'd0) m_rf[wb_addr] = wb_data;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    drive(0, 32'h0, 0, 1, 16'h0, 0, 4'h0, 16'h0);
    @(posedge clk);
    #1;

    // rst, ins, iv, er, ans, we, wa, wd | chk_rdy, rdy, op, v, chk_dat, A, B, din, rd
    tbl.push_back(mkv(0, 32'h0, 0, 1, 16'h0, 0, 4'd0, 16'h0,       0, 1, NOP, 0, 1, 16'h0, 16'h0, 16'h0, 4'd0));
    tbl.push_back(mkv(0, 32'h0, 0, 1, 16'h0, 0, 4'd0, 16'h0,       1, 1, NOP, 0, 1, 16'h0, 16'h0, 16'h0, 4'd0));
    tbl.push_back(mkv(1, mk_r(ADD, 0, 7, 8), 1, 1, 16'h0, 0, 4'd0, 16'h0, 1, 1, ADD, 1, 1, 16'h0, 16'h0, 16'h0, 4'd0));
    tbl.push_back(mkv(1, 32'h0, 0, 1, 16'h0, 1, 4'd1, 16'h0004,    1, 1, NOP, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0));
    tbl.push_back(mkv(1, 32'h0, 0, 1, 16'h0, 1, 4'd2, 16'h0004,    1, 1, NOP, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0));
    tbl.push_back(mkv(1, mk_r(ADD, 3, 1, 2), 1, 1, 16'h0, 0, 4'd0, 16'h0, 1, 1, ADD, 1, 1, 16'h4, 16'h4, 16'h0, 4'd3));
    tbl.push_back(mkv(1, mk_r(ADD, 6, 3, 0), 1, 1, 16'h0008, 0, 4'd0, 16'h0, 1, 1, ADD, 1, 1, 16'h8, 16'h0, 16'h0, 4'd6));
    tbl.push_back(mkv(1, mk_r(LD, 5, 1, 0), 1, 1, 16'h1111, 0, 4'd0, 16'h0, 1, 1, LD, 1, 1, 16'h4, 16'h0, 16'h0, 4'd5));
    tbl.push_back(mkv(1, mk_r(ADD, 7, 5, 2), 1, 1, 16'hDEAD, 0, 4'd0, 16'h0, 1, 0, NOP, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0));
    tbl.push_back(mkv(1, mk_r(ADD, 7, 5, 2), 1, 1, 16'hBEEF, 1, 4'd5, 16'h1234, 1, 1, ADD, 1, 1, 16'h1234, 16'h4, 16'h0, 4'd7));
    tbl.push_back(mkv(1, mk_i(ADD, 8, 0, 16'hC000), 1, 1, 16'h0007, 1, 4'd4, 16'h0008, 1, 1, ADD, 1, 1, 16'h0, 16'hC000, 16'h0, 4'd8));
    tbl.push_back(mkv(1, mk_r(ST, 4, 2, 0), 1, 1, 16'h5555, 0, 4'd0, 16'h0, 1, 1, ST, 1, 1, 16'h4, 16'h0, 16'h8, 4'd4));
    tbl.push_back(mkv(1, mk_r(ADD, 9, 4, 4), 1, 1, 16'h9999, 0, 4'd0, 16'h0, 1, 1, ADD, 1, 1, 16'h8, 16'h8, 16'h0, 4'd9));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(1, mk_r(ADD, 10, 0, 1), 1, 0, 16'h7000 + 16'(i), 1, 4'd0, 16'hFFFF,
                        1, 0, ADD, 1, 1, 16'h8, 16'h8, 16'h0, 4'd9));
    tbl.push_back(mkv(1, mk_r(ADD, 10, 0, 1), 1, 1, 16'h0, 1, 4'd0, 16'hFFFF, 1, 1, ADD, 1, 1, 16'h0, 16'h4, 16'h0, 4'd10));
    tbl.push_back(mkv(1, 32'h0, 0, 1, 16'h0, 0, 4'd0, 16'h0,       1, 1, NOP, 0, 0, 16'h0, 16'h0, 16'h0, 4'd0));

    for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset arriving while a load-use stall is pending: the stalled instruction is dropped,
    // tracking and registers clear, and the re-presented instruction issues at once reading R5=0.
    run_vec("rst_stall0", mkv(1, mk_r(LD, 5, 0, 0), 1, 1, 16'h0, 0, 4'd0, 16'h0, 1, 1, LD, 1, 1, 16'h0, 16'h0, 16'h0, 4'd5));
    run_vec("rst_stall1", mkv(0, mk_r(ADD, 6, 5, 0), 1, 1, 16'h0, 0, 4'd0, 16'h0, 1, 0, NOP, 0, 1, 16'h0, 16'h0, 16'h0, 4'd0));
    run_vec("rst_stall2", mkv(1, mk_r(ADD, 6, 5, 0), 1, 1, 16'hAAAA, 0, 4'd0, 16'h0, 1, 1, ADD, 1, 1, 16'h0, 16'h0, 16'h0, 4'd6));

    // Random traffic against the model; small register range to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      logic [5:0]  op;
      logic [3:0]  rd, rs, rt;
      logic [31:0] ins;
      int          sel;
      sel = $urandom_range(0, 7);
      op  = (sel == 0) ? LD : (sel == 1) ? ST : (sel == 2) ? NOP : 6'($urandom);
      rd  = 4'($urandom_range(0, 7));
      rs  = 4'($urandom_range(0, 7));
      rt  = 4'($urandom_range(0, 7));
      ins = ($urandom_range(0, 3) == 0) ? mk_i(op, rd, rs, 16'($urandom)) : mk_r(op, rd, rs, rt);
      drive((c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0), ins,
            $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 16'($urandom),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), 16'($urandom));
      @(negedge clk);
      if (c > 0) check("rand.ready", {31'b0, instr_ready}, {31'b0, m_ready()});
      model_step();
      @(posedge clk);
      #1;
      check("rand.op_dec", {26'b0, op_dec}, {26'b0, m_op});
      check("rand.valid_ex", {31'b0, valid_ex}, {31'b0, m_v});
      if (m_v) begin
        check("rand.A", {16'b0, a_out}, {16'b0, m_a});
        check("rand.B", {16'b0, b_out}, {16'b0, m_b});
        check("rand.data_in", {16'b0, data_in}, {16'b0, m_din});
        check("rand.rd_ex", {28'b0, rd_ex}, {28'b0, m_rd});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
